// File: rtl/line_fetch_sequencer.sv
// Per-scanline tile fetch sequencer: walks FETCHES 16-pixel slots per line,
// presenting tile_bram coordinates and line-buffer x under a valid/ready handshake.
module line_fetch_sequencer #(
    parameter int CORDW   = 11,
    parameter int FETCHES = 41
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             line,
    input  logic [CORDW-1:0] sy,
    input  logic [10:0]      scroll_x,
    input  logic             ready,
    output logic             valid,
    output logic [4:0]       tile_y,
    output logic [2:0]       tile_row,
    output logic [4:0]       tile_x,
    output logic             tile_col,
    output logic [10:0]      lb_x,
    output logic             bufsel,
    output logic             line_start,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t      state, state_next;
    logic [6:0]  idx;
    logic [5:0]  tc;
    logic        hs;
    logic        last;
    logic        unused_bits;

    assign hs   = (state == FETCH) && ready;
    assign last = (idx == 7'(FETCHES - 1));

    // Map is 64 half-tiles wide, and rows repeat every 4 lines, so these bits never matter.
    assign unused_bits = ^{scroll_x[10], sy[CORDW-1:10], sy[1]};

    always_ff @(posedge clk_pix) begin
        if (rst_pix) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (line) begin
            state_next = FETCH;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                FETCH:   if (ready && last) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        valid = (state == FETCH);
        busy  = (state == FETCH);
        done  = (state == DONE);
    end

    // Counters stop on the final slot so coordinates hold their last value after the line.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            idx        <= '0;
            tc         <= '0;
            lb_x       <= '0;
            tile_y     <= '0;
            tile_row   <= '0;
            bufsel     <= 1'b0;
            line_start <= 1'b0;
        end else begin
            line_start <= line;
            if (line) begin
                idx      <= '0;
                tc       <= scroll_x[9:4];
                lb_x     <= 11'd0 - {7'd0, scroll_x[3:0]};
                tile_y   <= sy[9:5];
                tile_row <= sy[4:2];
                bufsel   <= sy[0];
            end else if (hs && !last) begin
                idx  <= idx + 7'd1;
                tc   <= tc + 6'd1;
                lb_x <= lb_x + 11'd16;
            end
        end
    end

    assign tile_x   = tc[5:1];
    assign tile_col = tc[0];

endmodule

// File: tb/tb_line_fetch_sequencer.sv
// Randomized and directed bench for line_fetch_sequencer against a slot-index
// reference model that computes each slot's coordinates arithmetically.
module tb_line_fetch_sequencer;

    localparam int CORDW   = 11;
    localparam int FETCHES = 41;

    logic             clk_pix = 1'b0;
    logic             rst_pix = 1'b1;
    logic             line = 1'b0;
    logic [CORDW-1:0] sy = '0;
    logic [10:0]      scroll_x = '0;
    logic             ready = 1'b0;
    logic             valid;
    logic [4:0]       tile_y;
    logic [2:0]       tile_row;
    logic [4:0]       tile_x;
    logic             tile_col;
    logic [10:0]      lb_x;
    logic             bufsel;
    logic             line_start;
    logic             busy;
    logic             done;

    always #5 clk_pix = ~clk_pix;

    line_fetch_sequencer #(.CORDW(CORDW), .FETCHES(FETCHES)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .line(line), .sy(sy),
        .scroll_x(scroll_x), .ready(ready), .valid(valid), .tile_y(tile_y),
        .tile_row(tile_row), .tile_x(tile_x), .tile_col(tile_col), .lb_x(lb_x),
        .bufsel(bufsel), .line_start(line_start), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: fetching flag, slot number and the values captured on line.
    bit m_fetch = 0, m_done = 0, m_ls = 0, m_have = 0;
    int m_k = 0, m_sy = 0, m_sx = 0;
    int m_hs = 0, m_ndone = 0, d_hs = 0, d_done = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic compare_all();
        int tc, e_ty, e_tr, e_bs, e_lb;
        tc   = m_have ? ((((m_sx >> 4) & 63) + m_k) % 64) : 0;
        e_ty = m_have ? ((m_sy >> 5) & 31) : 0;
        e_tr = m_have ? ((m_sy >> 2) & 7) : 0;
        e_bs = m_have ? (m_sy & 1) : 0;
        e_lb = m_have ? ((m_k * 16 - (m_sx & 15)) & 2047) : 0;
        chk("valid", int'(valid), int'(m_fetch));
        chk("busy", int'(busy), int'(m_fetch));
        chk("done", int'(done), int'(m_done));
        chk("line_start", int'(line_start), int'(m_ls));
        chk("tile_y", int'(tile_y), e_ty);
        chk("tile_row", int'(tile_row), e_tr);
        chk("bufsel", int'(bufsel), e_bs);
        chk("tile_x", int'(tile_x), tc >> 1);
        chk("tile_col", int'(tile_col), tc & 1);
        chk("lb_x", int'(lb_x), e_lb);
    endtask

    task automatic step(input bit r, input bit l, input int s_y, input int s_x, input bit rd);
        rst_pix  = r;
        line     = l;
        sy       = CORDW'(s_y);
        scroll_x = 11'(s_x);
        ready    = rd;
        if (valid && rd && !l && !r) d_hs++;
        if (r) begin
            m_fetch = 0; m_done = 0; m_ls = 0; m_have = 0; m_k = 0;
        end else if (l) begin
            m_fetch = 1; m_done = 0; m_ls = 1; m_have = 1; m_k = 0;
            m_sy = s_y; m_sx = s_x;
        end else begin
            m_ls   = 0;
            m_done = 0;
            if (m_fetch && rd) begin
                m_hs++;
                if (m_k == FETCHES - 1) begin
                    m_fetch = 0; m_done = 1; m_ndone++;
                end else begin
                    m_k++;
                end
            end
        end
        @(posedge clk_pix);
        @(negedge clk_pix);
        if (done) d_done++;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rd);
    endtask

    task automatic clear_counts();
        m_hs = 0; m_ndone = 0; d_hs = 0; d_done = 0;
    endtask

    initial begin
        @(negedge clk_pix);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("rst_valid", int'(valid), 0);
        chk("rst_lb_x", int'(lb_x), 0);
        idle(3, 1);

        // Basic line
        clear_counts();
        step(0, 1, 37, 0, 1);
        chk("basic_ls", int'(line_start), 1);
        chk("basic_ty", int'(tile_y), 1);
        chk("basic_tr", int'(tile_row), 1);
        chk("basic_bs", int'(bufsel), 1);
        chk("basic_tx0", int'(tile_x), 0);
        chk("basic_lb0", int'(lb_x), 0);
        step(0, 0, 0, 0, 1);
        chk("basic_col1", int'(tile_col), 1);
        chk("basic_lb1", int'(lb_x), 16);
        chk("basic_ls_gone", int'(line_start), 0);
        idle(39, 1);
        chk("basic_tx40", int'(tile_x), 20);
        chk("basic_col40", int'(tile_col), 0);
        chk("basic_lb40", int'(lb_x), 640);
        step(0, 0, 0, 0, 1);
        chk("basic_done", int'(done), 1);
        chk("basic_valid_off", int'(valid), 0);
        step(0, 0, 0, 0, 1);
        chk("basic_done_once", int'(done), 0);
        chk("basic_hs", d_hs, FETCHES);

        // Scroll wrap
        step(0, 1, 37, 'h3F5, 1);
        chk("wrap_tx0", int'(tile_x), 31);
        chk("wrap_col0", int'(tile_col), 1);
        chk("wrap_lb0", int'(lb_x), 2043);
        step(0, 0, 0, 0, 1);
        chk("wrap_tx1", int'(tile_x), 0);
        chk("wrap_col1", int'(tile_col), 0);
        chk("wrap_lb1", int'(lb_x), 11);
        idle(45, 1);

        // Backpressure at slot 5
        clear_counts();
        step(0, 1, 100, 23, 1);
        idle(5, 1);
        chk("bp_lb5", int'(lb_x), (5 * 16 - 7) & 2047);
        idle(3, 0);
        chk("bp_lb_frozen", int'(lb_x), (5 * 16 - 7) & 2047);
        idle(50, 1);
        chk("bp_hs", d_hs, FETCHES);
        chk("bp_done", d_done, 1);

        // Restart at slot 10
        clear_counts();
        step(0, 1, 37, 0, 1);
        idle(10, 1);
        step(0, 1, 64, 0, 1);
        chk("rs_ls", int'(line_start), 1);
        chk("rs_ty", int'(tile_y), 2);
        chk("rs_tr", int'(tile_row), 0);
        chk("rs_bs", int'(bufsel), 0);
        chk("rs_lb", int'(lb_x), 0);
        idle(45, 1);
        chk("rs_done", d_done, 1);

        // Reset at slot 7
        clear_counts();
        step(0, 1, 255, 77, 1);
        idle(7, 1);
        step(1, 0, 0, 0, 1);
        chk("mr_valid", int'(valid), 0);
        chk("mr_tx", int'(tile_x), 0);
        chk("mr_lb", int'(lb_x), 0);
        idle(50, 1);
        chk("mr_no_done", d_done, 0);
        step(0, 1, 9, 300, 1);
        idle(45, 1);
        chk("mr_after_done", d_done, 1);

        // Back-to-back lines, 800 cycles apart
        for (int ln = 0; ln < 2; ln++) begin
            clear_counts();
            step(0, 1, 200 + ln, 48, 1);
            chk("b2b_bufsel", int'(bufsel), ln & 1);
            idle(799, 1);
            chk("b2b_hs", d_hs, FETCHES);
            chk("b2b_done", d_done, 1);
        end

        // Randomized traffic
        clear_counts();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 79) == 0),
                 int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 2047)),
                 ($urandom_range(0, 3) != 0));
        end
        chk("rand_hs", d_hs, m_hs);
        chk("rand_done", d_done, m_ndone);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_fetch_sequencer.md
Name: line_fetch_sequencer

Overview:
Per-scanline tile fetch sequencer. It sits between the VGA timing generator and tile_bram / pixel_quadrupler in the draw pipeline. On each start-of-line pulse it walks a fixed number of 16-pixel fetch slots. Each slot drives tile_bram coordinates and the matching line-buffer x position, with a valid/ready handshake and horizontal scroll support.

Parameters:
CORDW, 11, coordinate width of sy input
FETCHES, 41, fetch slots per line (each covers 16 screen pixels; 640/16 plus 1 for fine scroll); legal range 1..127

Ports:
clk_pix  in  1  pixel/draw clock
rst_pix  in  1  synchronous active-high reset
line  in  1  start-of-line pulse from vga
sy  in  CORDW  current scanline, sampled on line
scroll_x  in  11  horizontal scroll in screen pixels, sampled on line
ready  in  1  downstream accepts current fetch this cycle
valid  out  1  tile coordinates and lb_x are a live fetch
tile_y  out  5  tile row index, sy[9:5]
tile_row  out  3  row within tile, sy[4:2] (each row repeated 4 lines)
tile_x  out  5  tile column index
tile_col  out  1  half-tile (4-pixel word) select
lb_x  out  11  line-buffer x of this fetch's first pixel, mod 2048
bufsel  out  1  line buffer select, sy[0], held for whole line
line_start  out  1  one-cycle pulse, downstream reset for quadrupler/aligner
busy  out  1  high while in FETCH
done  out  1  one-cycle pulse after last fetch accepted

Behaviour:
- Reset values:
  - state IDLE
  - valid, line_start, busy and done all 0
  - tile_y, tile_row, tile_x, tile_col, lb_x and bufsel all 0
- States:
  - IDLE: on line -> FETCH.
  - FETCH: on handshake (valid&&ready) with idx==FETCHES-1 -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- Start of line (line=1 at cycle N, any state including FETCH/DONE = abort and restart). At N+1:
  - state=FETCH, valid=1, busy=1, line_start=1.
  - tile_y=sy[9:5], tile_row=sy[4:2], bufsel=sy[0].
  - Slot index idx=0.
  - Tile counter tc (6 bits) = scroll_x[9:4]; tile_x=tc[5:1], tile_col=tc[0].
  - lb_x = (0 - scroll_x[3:0]) mod 2048; e.g. fine=0 -> 0, fine=5 -> 2043.
- Advance on handshake: idx+1, tc+1 mod 64 (tile_x wraps 31->0), lb_x+16 mod 2048. Outputs update the next cycle.
- ready=0 while valid: all outputs hold stable. No slot is skipped or repeated.
- After the last handshake: valid=0 and busy=0 next cycle, done=1 that cycle. Coordinate outputs hold their last value.
- line and handshake in the same cycle: line wins, and the slot counts as discarded.
- line_start is high only in the cycle after line, never otherwise; it is independent of ready.
- Outside FETCH: valid=0 and coordinate outputs hold.
- scroll_x[10] is ignored (tile map is 64 half-tiles wide).
- Fetches whose lb_x >= 640 write off-screen line-buffer area; this is legal.
- rst_pix mid-line: IDLE immediately next cycle, all outputs at reset values, no done pulse.

Test Plan:
- Basic line, FETCHES=41, sy=37, scroll_x=0, ready=1:
  - cycle N+1: valid=1, line_start=1, tile_y=1, tile_row=1, bufsel=1, tile_x=0, col=0, lb_x=0.
  - next slot: col=1, lb_x=16.
  - 41st slot: tile_x=20, col=0, lb_x=640.
  - then done=1 for one cycle, valid=0.
- Scroll wrap, scroll_x=0x3F5:
  - first slot: tile_x=31, col=1, lb_x=2043.
  - second slot: tile_x=0, col=0, lb_x=11.
- Backpressure: ready low for 3 cycles at slot 5 -> outputs frozen for those 3 cycles, then slot 6 values. Total handshakes still 41; done is delayed by 3 cycles.
- Restart: line re-asserted at slot 10 with sy=64 -> next cycle idx 0, tile_y=2, tile_row=0, bufsel=0, line_start=1. No done from the aborted line.
- Reset mid-line: rst_pix at slot 7 -> next cycle all outputs 0 and IDLE. No done. A subsequent line pulse starts normally.
- Back-to-back lines: line pulses 800 cycles apart with ready=1 -> exactly 41 handshakes and one done per line. bufsel follows sy[0].
